// File: rtl/arf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arf_pkg
// Description : Operation codes and shared next-value function for the
//               address register file.
// Revision    : 1.0 - initial release
// ============================================================================
package arf_pkg;

    localparam logic [2:0] FS_DEC     = 3'b000;
    localparam logic [2:0] FS_INC     = 3'b001;
    localparam logic [2:0] FS_LOAD    = 3'b010;
    localparam logic [2:0] FS_CLEAR   = 3'b011;
    localparam logic [2:0] FS_ADD     = 3'b100;
    localparam logic [2:0] FS_LOAD_LO = 3'b101;
    localparam logic [2:0] FS_LOAD_HI = 3'b110;
    localparam logic [2:0] FS_HOLD    = 3'b111;

    // Widest register the shared function supports; callers truncate to their width.
    localparam int unsigned c_arf_max_w = 64;

    function automatic logic [c_arf_max_w-1:0] arf_next(
        input logic [c_arf_max_w-1:0] q,
        input logic [c_arf_max_w-1:0] d,
        input logic [2:0]             fs,
        input int unsigned            w
    );
        logic [c_arf_max_w-1:0] lo_mask;
        lo_mask = {c_arf_max_w{1'b1}} >> (c_arf_max_w - w / 2);
        case (fs)
            FS_DEC:     arf_next = q - 1'b1;
            FS_INC:     arf_next = q + 1'b1;
            FS_LOAD:    arf_next = d;
            FS_CLEAR:   arf_next = '0;
            FS_ADD:     arf_next = q + d;
            FS_LOAD_LO: arf_next = (q & ~lo_mask) | (d & lo_mask);
            FS_LOAD_HI: arf_next = ((d & lo_mask) << (w / 2)) | (q & lo_mask);
            default:    arf_next = q;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/addr_reg.sv
`default_nettype none
// ============================================================================
// Module      : addr_reg
// Description : Single address register with enable, operation decode and
//               synchronous reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_reg
    import arf_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [2:0]       i_fs,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = WIDTH'(arf_next(c_arf_max_w'(r_q), c_arf_max_w'(i_data), i_fs, WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/address_register_file_p.sv
`default_nettype none
// ============================================================================
// Module      : address_register_file_p
// Description : Parametrised PC/AR/SP address register file with two read
//               ports and a bounds-checked stack pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module address_register_file_p
    import arf_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               NUM_REGS    = 4,
    parameter int               PC_INDEX    = 0,
    parameter int               SP_INDEX    = NUM_REGS - 1,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter logic [WIDTH-1:0] SP_LIMIT_LO = WIDTH'(16'h0100),
    parameter logic [WIDTH-1:0] SP_LIMIT_HI = WIDTH'(16'hFFFF)
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [WIDTH-1:0]            I,
    input  logic [2:0]                  FunSel,
    input  logic [NUM_REGS-1:0]         RegSel,
    input  logic [$clog2(NUM_REGS)-1:0] OutCSel,
    input  logic [$clog2(NUM_REGS)-1:0] OutDSel,
    input  logic                        FlagClr,
    output logic [WIDTH-1:0]            OutC,
    output logic [WIDTH-1:0]            OutD,
    output logic                        StackOvf,
    output logic                        StackUnf
);

    logic [WIDTH-1:0] w_q [NUM_REGS];
    logic             w_sp_sel;
    logic             w_ovf_hit;
    logic             w_unf_hit;
    logic             w_sp_en;
    logic             r_ovf;
    logic             r_unf;

    // The guard only blocks a step that would cross a limit from exactly on it.
    assign w_sp_sel  = ~RegSel[SP_INDEX];
    assign w_ovf_hit = w_sp_sel && (FunSel == FS_DEC) && (w_q[SP_INDEX] == SP_LIMIT_LO);
    assign w_unf_hit = w_sp_sel && (FunSel == FS_INC) && (w_q[SP_INDEX] == SP_LIMIT_HI);
    assign w_sp_en   = w_sp_sel && !w_ovf_hit && !w_unf_hit;

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
            localparam logic [WIDTH-1:0] c_rst_val = (k == PC_INDEX) ? RESET_PC :
                                                     (k == SP_INDEX) ? SP_LIMIT_HI : '0;
            logic w_en;

            if (k == SP_INDEX) begin : g_sp_en
                assign w_en = w_sp_en;
            end else begin : g_plain_en
                assign w_en = ~RegSel[k];
            end

            addr_reg #(
                .WIDTH     (WIDTH),
                .RESET_VAL (c_rst_val)
            ) u_reg (
                .clk    (Clock),
                .rst    (Reset),
                .i_en   (w_en),
                .i_fs   (FunSel),
                .i_data (I),
                .o_q    (w_q[k])
            );
        end
    endgenerate

    // A new violation wins over a simultaneous clear.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_hit) begin
                r_ovf <= 1'b1;
            end else if (FlagClr) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_hit) begin
                r_unf <= 1'b1;
            end else if (FlagClr) begin
                r_unf <= 1'b0;
            end
        end
    end

    always_comb begin
        OutC = '0;
        OutD = '0;
        if (int'(OutCSel) < NUM_REGS) begin
            OutC = w_q[OutCSel];
        end
        if (int'(OutDSel) < NUM_REGS) begin
            OutD = w_q[OutDSel];
        end
    end

    assign StackOvf = r_ovf;
    assign StackUnf = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_address_register_file_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_address_register_file_p
// Description : Scoreboard bench for address_register_file_p (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_address_register_file_p;
    import arf_pkg::*;

    localparam int W = 16;
    localparam int N = 4;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic         Clock = 1'b0;
    logic         Reset;
    logic [W-1:0] I;
    logic [2:0]   FunSel;
    logic [N-1:0] RegSel;
    logic [1:0]   OutCSel;
    logic [1:0]   OutDSel;
    logic         FlagClr;
    logic [W-1:0] OutC;
    logic [W-1:0] OutD;
    logic         StackOvf;
    logic         StackUnf;

    address_register_file_p dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .I        (I),
        .FunSel   (FunSel),
        .RegSel   (RegSel),
        .OutCSel  (OutCSel),
        .OutDSel  (OutDSel),
        .FlagClr  (FlagClr),
        .OutC     (OutC),
        .OutD     (OutD),
        .StackOvf (StackOvf),
        .StackUnf (StackUnf)
    );

    always #5 Clock = ~Clock;

    int           n_tests = 0;
    int           n_fail  = 0;
    exp_t         sb[$];
    logic [W-1:0] m_q [N];
    logic         m_ovf;
    logic         m_unf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] q, input logic [W-1:0] d,
                                            input logic [2:0] fs);
        case (fs)
            3'd0:    return q - 16'd1;
            3'd1:    return q + 16'd1;
            3'd2:    return d;
            3'd3:    return 16'd0;
            3'd4:    return q + d;
            3'd5:    return {q[15:8], d[7:0]};
            3'd6:    return {d[7:0], q[7:0]};
            default: return q;
        endcase
    endfunction

    // Drive one operation, advance the model, and let it through one rising edge.
    task automatic apply(input logic rst, input logic [2:0] fs, input logic [N-1:0] sel,
                         input logic [W-1:0] d, input logic clr);
        logic ovf_set;
        logic unf_set;
        @(negedge Clock);
        Reset = rst; FunSel = fs; RegSel = sel; I = d; FlagClr = clr;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (rst) begin
            m_q[0] = 16'h0000; m_q[1] = 16'h0000; m_q[2] = 16'h0000; m_q[3] = 16'hFFFF;
            m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!sel[k]) begin
                    if (k == 3 && fs == 3'd0 && m_q[3] == 16'h0100) ovf_set = 1'b1;
                    else if (k == 3 && fs == 3'd1 && m_q[3] == 16'hFFFF) unf_set = 1'b1;
                    else m_q[k] = ref_op(m_q[k], d, fs);
                end
            end
            if (ovf_set) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
            if (unf_set) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
        end
        @(posedge Clock);
        #1;
        Reset = 1'b0; FunSel = FS_HOLD; RegSel = '1; FlagClr = 1'b0;
    endtask

    // Push expectations for every index on both ports and the flags, then drain.
    task automatic sweep();
        exp_t e;
        sb.push_back('{"StackOvf", 32'(m_ovf)});
        sb.push_back('{"StackUnf", 32'(m_unf)});
        e = sb.pop_front(); check_val(e.tag, 32'(StackOvf), e.exp);
        e = sb.pop_front(); check_val(e.tag, 32'(StackUnf), e.exp);
        for (int k = 0; k < N; k++) begin
            OutCSel = 2'(k);
            OutDSel = 2'(N - 1 - k);
            sb.push_back('{$sformatf("OutC[%0d]", k), 32'(m_q[k])});
            sb.push_back('{$sformatf("OutD[%0d]", N - 1 - k), 32'(m_q[N - 1 - k])});
            #1;
            e = sb.pop_front(); check_val(e.tag, 32'(OutC), e.exp);
            e = sb.pop_front(); check_val(e.tag, 32'(OutD), e.exp);
        end
    endtask

    task automatic read_reg(input int k, output logic [W-1:0] v);
        OutCSel = 2'(k);
        #1;
        v = OutC;
    endtask

    initial begin
        logic [W-1:0] v;
        Reset = 1'b1; I = '0; FunSel = FS_HOLD; RegSel = '1;
        OutCSel = '0; OutDSel = '0; FlagClr = 1'b0;

        apply(1'b1, FS_HOLD, 4'b1111, 16'h0, 1'b0); sweep();
        read_reg(3, v); check_val("reset_sp", 32'(v), 32'h0000FFFF);

        // AR: LOAD, LOAD_HI, ADD
        apply(1'b0, FS_LOAD,    4'b1101, 16'h1234, 1'b0); sweep();
        apply(1'b0, FS_LOAD_HI, 4'b1101, 16'h00AB, 1'b0); sweep();
        read_reg(1, v); check_val("ar_load_hi", 32'(v), 32'h0000AB34);
        apply(1'b0, FS_ADD,     4'b1101, 16'h0010, 1'b0); sweep();
        read_reg(1, v); check_val("ar_add", 32'(v), 32'h0000AB44);
        apply(1'b0, FS_LOAD_LO, 4'b1101, 16'h77CD, 1'b0); sweep();
        read_reg(1, v); check_val("ar_load_lo", 32'(v), 32'h0000ABCD);

        // PC wraps silently
        apply(1'b0, FS_LOAD, 4'b1110, 16'hFFFF, 1'b0);
        apply(1'b0, FS_INC,  4'b1110, 16'h0000, 1'b0); sweep();
        read_reg(0, v); check_val("pc_wrap", 32'(v), 32'h00000000);

        // SP lower limit
        apply(1'b0, FS_LOAD, 4'b0111, 16'h0101, 1'b0);
        apply(1'b0, FS_DEC,  4'b0111, 16'h0000, 1'b0); sweep();
        check_val("ovf_first_dec", 32'(StackOvf), 32'd0);
        apply(1'b0, FS_DEC,  4'b0111, 16'h0000, 1'b0); sweep();
        apply(1'b0, FS_DEC,  4'b0111, 16'h0000, 1'b0); sweep();
        read_reg(3, v); check_val("sp_lo_hold", 32'(v), 32'h00000100);
        check_val("ovf_set", 32'(StackOvf), 32'd1);

        // SP upper limit, clear, clear vs set
        apply(1'b0, FS_LOAD, 4'b0111, 16'hFFFF, 1'b0);
        apply(1'b0, FS_INC,  4'b0111, 16'h0000, 1'b0); sweep();
        check_val("unf_set", 32'(StackUnf), 32'd1);
        apply(1'b0, FS_HOLD, 4'b1111, 16'h0000, 1'b1); sweep();
        check_val("unf_clr", 32'(StackUnf), 32'd0);
        apply(1'b0, FS_INC,  4'b0111, 16'h0000, 1'b1); sweep();
        check_val("unf_set_wins", 32'(StackUnf), 32'd1);

        // Reset beats a simultaneous LOAD
        apply(1'b1, FS_LOAD, 4'b0000, 16'h5555, 1'b0); sweep();
        read_reg(2, v); check_val("reset_wins", 32'(v), 32'h00000000);

        // PC and SP together at the SP lower limit
        apply(1'b0, FS_LOAD, 4'b1110, 16'h0005, 1'b0);
        apply(1'b0, FS_LOAD, 4'b0111, 16'h0100, 1'b0);
        apply(1'b0, FS_DEC,  4'b0110, 16'h0000, 1'b0); sweep();
        read_reg(0, v); check_val("pc_dec_multi", 32'(v), 32'h00000004);
        read_reg(3, v); check_val("sp_hold_multi", 32'(v), 32'h00000100);
        check_val("ovf_multi", 32'(StackOvf), 32'd1);

        // Out-of-bounds SP wraps without flags; then random mix
        apply(1'b0, FS_CLEAR, 4'b0111, 16'h0000, 1'b1);
        apply(1'b0, FS_DEC,   4'b0111, 16'h0000, 1'b0); sweep();
        check_val("oob_no_flag", 32'(StackOvf), 32'd0);
        for (int t = 0; t < 40; t++) begin
            apply(1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  16'($urandom), 1'($urandom_range(0, 1)));
            sweep();
        end

        if (sb.size() != 0) check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/address_register_file_p.md
Name: address_register_file_p

Overview:
- Parametrised successor of the 16-bit three-register address register file (PC/AR/SP).
- Holds NUM_REGS address registers of WIDTH bits, with one shared input bus and one shared operation code.
- Each register has its own active-low write-enable.
- Two independent combinational read ports feed the memory-address mux and the ALU-system bus.
- New over the previous generation: synchronous reset with a configurable PC reset vector, extended operations (add, half loads), and a bounds-checked stack pointer with sticky overflow/underflow flags.

Parameters:
- WIDTH, 16: register and bus width in bits; must be even and ≥ 4.
- NUM_REGS, 4: number of address registers; must be ≥ 2.
- PC_INDEX, 0: register index acting as program counter.
- SP_INDEX, NUM_REGS-1: register index acting as stack pointer; must differ from PC_INDEX.
- RESET_PC, 0: PC value after reset.
- SP_LIMIT_LO, 16'h0100: lowest legal SP value. Stack grows downward.
- SP_LIMIT_HI, 16'hFFFF: highest legal SP value; also the SP reset value. Requires SP_LIMIT_LO < SP_LIMIT_HI.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- I  in  WIDTH  write/operand data.
- FunSel  in  3  operation code applied to every enabled register.
- RegSel  in  NUM_REGS  active-low per-register enable; bit k controls register k.
- OutCSel  in  $clog2(NUM_REGS)  read-port C select.
- OutDSel  in  $clog2(NUM_REGS)  read-port D select.
- FlagClr  in  1  clears both sticky stack flags.
- OutC  out  WIDTH  value of register OutCSel.
- OutD  out  WIDTH  value of register OutDSel.
- StackOvf  out  1  sticky flag: a DEC was attempted with SP at SP_LIMIT_LO.
- StackUnf  out  1  sticky flag: an INC was attempted with SP at SP_LIMIT_HI.

Behaviour:
- Reset (synchronous, active-high) has priority over all other inputs in that cycle:
  - PC ← RESET_PC; SP ← SP_LIMIT_HI; all other registers ← 0.
  - StackOvf ← 0; StackUnf ← 0.
  - OutC/OutD reflect the reset values one cycle after the reset edge.
- FunSel encoding, applied on the rising edge to each register k with RegSel[k] = 0:
  - 000 DEC: Q−1.
  - 001 INC: Q+1.
  - 010 LOAD: I.
  - 011 CLEAR: 0.
  - 100 ADD: Q+I.
  - 101 LOAD_LO: {Q[W-1:W/2], I[W/2-1:0]}.
  - 110 LOAD_HI: {I[W/2-1:0], Q[W/2-1:0]}.
  - 111 HOLD.
- Registers with RegSel[k] = 1 hold their value.
- Arithmetic is modulo 2^WIDTH; non-SP registers wrap silently (e.g. INC of all-ones gives 0).
- SP guard (applies only to register SP_INDEX):
  - DEC with SP == SP_LIMIT_LO: SP holds; StackOvf ← 1.
  - INC with SP == SP_LIMIT_HI: SP holds; StackUnf ← 1.
  - LOAD, CLEAR, ADD, LOAD_LO and LOAD_HI are unguarded; the SP may be moved out of bounds by these operations.
  - DEC/INC on an out-of-bounds SP wraps normally with no flag set.
- Flags:
  - Both flags are sticky until Reset or FlagClr.
  - FlagClr together with a new violation in the same cycle: the set wins (the flag stays 1).
- Multiple registers enabled: all of them apply the same FunSel with the same I; the guard is evaluated on the SP alone.
- Read ports:
  - Purely combinational from the current register state; no write-through bypass.
  - A value written on edge n appears on OutC/OutD after edge n.
  - A select ≥ NUM_REGS returns 0.
  - Both ports may select the same register.
- Latency: one cycle for every write operation; zero for reads.

Decomposition:
- Package arf_pkg:
  - FunSel localparams (FS_DEC … FS_HOLD).
  - Shared function computing the next value from (Q, I, FunSel).
- Sub-module addr_reg:
  - Single WIDTH register with enable, operation decode and synchronous reset value.
  - Its parameters are WIDTH and RESET_VAL.
  - Instantiated NUM_REGS times through generate.
- The SP guard and flag logic live in the top level; for SP_INDEX the guard gates that instance's enable.

Test Plan:
- Reset, then read every index on both ports → OutC = 0x0000 when PC reads RESET_PC = 0; SP reads 0xFFFF; other registers 0; flags 0; OutCSel beyond NUM_REGS (only possible when NUM_REGS is not a power of two) → 0.
- LOAD I = 0x1234 into AR (RegSel = 1101), then LOAD_HI I = 0x00AB → AR = 0xAB34; then ADD I = 0x0010 → 0xAB44; then INC PC from 0xFFFF → 0x0000 with no flag.
- LOAD SP = 0x0101, DEC, DEC, DEC → SP = 0x0100 after the first DEC and holds; StackOvf = 1 from the second DEC onward; StackUnf = 0.
- INC with SP = 0xFFFF → SP holds, StackUnf = 1; FlagClr alone → 0; FlagClr in the same cycle as another INC at the limit → StackUnf stays 1.
- Assert Reset in the same cycle as FunSel = LOAD with all RegSel = 0 and I = 0x5555 → reset values loaded, not 0x5555; flags cleared.
- Enable PC and SP together with DEC, SP at SP_LIMIT_LO and PC = 0x0005 → PC = 0x0004, SP holds, StackOvf = 1.
